// File: rtl/ralu_sequencer.sv
// RALU microprogram sequencer: writable microcode store, micro-PC,
// carry branch and watchdog, driving the RALU control word every cycle.
module ralu_sequencer #(
  parameter  int AW        = 4,
  parameter  int MAX_STEPS = 64,
  localparam int UW        = 19 + AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [UW-1:0] prog_data,
  input  logic          start,
  input  logic [AW-1:0] entry,
  input  logic          pout,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] upc,
  output logic [3:0]    S,
  output logic          M,
  output logic          Pin,
  output logic          ISR,
  output logic          ISL,
  output logic          A,
  output logic          wr,
  output logic [2:0]    adr,
  output logic [3:0]    v
);

  localparam int SW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [SW-1:0] LAST = SW'(MAX_STEPS - 1);

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JPO  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] upc_q, upc_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          err_q, err_d;
  logic          ctrl_en;
  logic          mem_we;

  logic [UW-1:0] mem_q [2**AW];
  logic [UW-1:0] word;
  logic [1:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] upc_inc;

  assign word    = mem_q[upc_q];
  assign op      = word[18:17];
  assign target  = word[18+AW:19];
  assign upc_inc = upc_q + AW'(1);

  // Microcode store: single write port, no reset, contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Sequencer state, micro-PC, step counter and sticky watchdog flag
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      steps_q <= steps_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept start in IDLE, sequence microwords in RUN
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    steps_d = steps_q;
    err_d   = err_q;
    ctrl_en = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_we = prog_we;
        if (start) begin
          upc_d   = entry;
          steps_d = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (op == OP_HALT) begin
          state_d = ST_DONE;
        end else begin
          ctrl_en = 1'b1;
          steps_d = steps_q + SW'(1);
          unique case (op)
            OP_JPO:  upc_d = pout ? target : upc_inc;
            OP_JMP:  upc_d = target;
            default: upc_d = upc_inc;
          endcase
          if (steps_q == LAST) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;
  assign upc  = upc_q;

  assign S   = ctrl_en ? word[3:0]   : 4'd0;
  assign M   = ctrl_en ? word[4]     : 1'b0;
  assign Pin = ctrl_en ? word[5]     : 1'b0;
  assign ISR = ctrl_en ? word[6]     : 1'b0;
  assign ISL = ctrl_en ? word[7]     : 1'b0;
  assign A   = ctrl_en ? word[8]     : 1'b0;
  assign wr  = ctrl_en ? word[9]     : 1'b0;
  assign adr = ctrl_en ? word[12:10] : 3'd0;
  assign v   = ctrl_en ? word[16:13] : 4'd0;

  logic unused_op;
  assign unused_op = (OP_NEXT == 2'b00);

endmodule

// File: tb/tb_ralu_sequencer.sv
// Bench for ralu_sequencer: per-cycle expectation tables pushed to a
// scoreboard queue at start and popped as the sequencer steps.
module tb_ralu_sequencer;

  localparam int AW = 4;
  localparam int UW = 19 + AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [UW-1:0] prog_data;
  logic          start;
  logic [AW-1:0] entry;
  logic          pout;
  logic          busy, done, err;
  logic [AW-1:0] upc;
  logic [3:0]    S;
  logic          M, Pin, ISR, ISL, A, wr;
  logic [2:0]    adr;
  logic [3:0]    v;

  int total = 0;
  int bad   = 0;

  ralu_sequencer #(.AW(AW), .MAX_STEPS(20)) dut (
    .clock(clock), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .entry(entry), .pout(pout),
    .busy(busy), .done(done), .err(err), .upc(upc),
    .S(S), .M(M), .Pin(Pin), .ISR(ISR), .ISL(ISL),
    .A(A), .wr(wr), .adr(adr), .v(v)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        pout;
    logic        st;
    logic        we;
    logic        rst;
    logic        busy;
    logic        done;
    logic        err;
    logic        cu;
    logic [3:0]  upc;
    logic [16:0] ctrl;
  } rec_t;

  rec_t tbl[$];
  rec_t exp_q[$];

  localparam logic [1:0] NX = 2'b00;
  localparam logic [1:0] JP = 2'b01;
  localparam logic [1:0] JM = 2'b10;
  localparam logic [1:0] HL = 2'b11;

  function automatic logic [16:0] cw(
    input logic [3:0] s, input logic m, input logic pin,
    input logic isr, input logic isl, input logic a,
    input logic w, input logic [2:0] ad, input logic [3:0] vv);
    return {vv, ad, w, a, isl, isr, pin, m, s};
  endfunction

  function automatic logic [UW-1:0] mw(
    input logic [16:0] c, input logic [1:0] op, input logic [3:0] t);
    return {t, op, c};
  endfunction

  function automatic rec_t R(
    input logic p, input logic st, input logic we, input logic rst,
    input logic b, input logic d, input logic e, input logic cu,
    input logic [3:0] u, input logic [16:0] c);
    rec_t r;
    r.pout = p; r.st = st; r.we = we; r.rst = rst;
    r.busy = b; r.done = d; r.err = e; r.cu = cu;
    r.upc = u; r.ctrl = c;
    return r;
  endfunction

  task automatic prog(input logic [3:0] a, input logic [UW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clock); #1;
    prog_we = 1'b0;
  endtask

  task automatic kick(input logic [3:0] e);
    entry = e; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_table(input string nm);
    rec_t r;
    logic [16:0] act;
    logic ok;
    int cyc;
    cyc = 0;
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    tbl.delete();
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      pout = r.pout; start = r.st; prog_we = r.we; reset = r.rst;
      #1;
      act = {v, adr, wr, A, ISL, ISR, Pin, M, S};
      ok = (busy === r.busy) && (done === r.done) && (err === r.err) &&
           (!r.cu || (upc === r.upc)) && (act === r.ctrl);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s[%0d]: got busy=%b done=%b err=%b upc=%0d ctrl=%h, want busy=%b done=%b err=%b upc=%0d ctrl=%h",
                 nm, cyc, busy, done, err, upc, act,
                 r.busy, r.done, r.err, r.upc, r.ctrl);
      end
      @(posedge clock); #1;
      start = 1'b0; prog_we = 1'b0; reset = 1'b0;
      cyc++;
    end
  endtask

  logic [16:0] c0, c1, c3, c7, c5n;
  logic [16:0] cn [16];
  logic [3:0]  u;

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; entry = '0; pout = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    tbl.push_back(R(0,0,0,0, 0,0,0,1, 0, 0));
    tbl.push_back(R(0,0,0,0, 0,0,0,1, 0, 0));
    run_table("reset");

    // Straight-line program; HALT word carries nonzero fields
    c0 = cw(0,0,0,0,0,1,0,0,4'b0001);
    c1 = cw(0,0,0,0,0,0,1,0,0);
    prog(0, mw(c0, NX, 0));
    prog(1, mw(c1, NX, 0));
    prog(2, mw(cw(4'hF,1,1,1,1,1,1,3'd7,4'hF), HL, 0));
    kick(0);
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 0, c0));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 1, c1));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 2, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 2, 0));
    tbl.push_back(R(0,0,0,0, 0,0,0,1, 2, 0));
    run_table("straight");

    // Branch on pout, plus unconditional jump
    c3 = cw(4'b1001,1,0,0,0,0,0,0,0);
    c7 = cw(0,0,0,0,0,0,0,3'd5,4'd2);
    prog(3, mw(c3, JP, 6));
    prog(4, mw(0, HL, 0));
    prog(6, mw(0, HL, 0));
    prog(7, mw(c7, JM, 3));
    kick(3);
    tbl.push_back(R(1,0,0,0, 1,0,0,1, 3, c3));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 6, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 6, 0));
    run_table("jpo_taken");
    kick(3);
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 3, c3));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 4, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 4, 0));
    run_table("jpo_not");
    kick(7);
    tbl.push_back(R(1,0,0,0, 1,0,0,1, 7, c7));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 3, c3));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 4, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 4, 0));
    run_table("jmp");

    // Write and start in the same idle cycle at the entry address
    prog(5, mw(cw(0,0,0,0,0,0,0,0,4'hA), HL, 0));
    c5n = cw(0,0,0,0,0,1,0,0,4'd5);
    prog_we = 1'b1; prog_addr = 5; prog_data = mw(c5n, NX, 0);
    kick(5);
    prog_we = 1'b0;
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 5, c5n));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 6, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 6, 0));
    run_table("we_start");

    // start/prog_we during RUN and DONE are ignored
    kick(0);
    entry = 9; prog_addr = 1;
    prog_data = mw(cw(4'hF,1,1,1,1,1,1,3'd7,4'hF), JM, 9);
    tbl.push_back(R(0,1,1,0, 1,0,0,1, 0, c0));
    tbl.push_back(R(0,1,1,0, 1,0,0,1, 1, c1));
    tbl.push_back(R(0,1,1,0, 1,0,0,1, 2, 0));
    tbl.push_back(R(0,1,1,0, 0,1,0,1, 2, 0));
    tbl.push_back(R(0,0,0,0, 0,0,0,1, 2, 0));
    run_table("busy_ign");
    kick(0);
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 0, c0));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 1, c1));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 2, 0));
    tbl.push_back(R(0,0,0,0, 0,1,0,1, 2, 0));
    run_table("store_kept");

    // All-NEXT store: wrap 15->0 and watchdog after 20 words
    for (int i = 0; i < 16; i++) begin
      cn[i] = cw(0,0,0,0,0,i[0],0,0,i[3:0]);
      prog(i[3:0], mw(cn[i], NX, 4'(15 - i)));
    end
    kick(14);
    for (int j = 0; j < 20; j++) begin
      u = 4'(14 + j);
      tbl.push_back(R(1,0,0,0, 1,0,0,1, u, cn[u]));
    end
    tbl.push_back(R(0,0,0,0, 0,1,1,0, 0, 0));
    tbl.push_back(R(0,0,0,0, 0,0,1,0, 0, 0));
    tbl.push_back(R(0,0,0,0, 0,0,1,0, 0, 0));
    run_table("watchdog");

    // Reset mid-run at upc=2; err cleared by the accepted start
    kick(0);
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 0, cn[0]));
    tbl.push_back(R(0,0,0,0, 1,0,0,1, 1, cn[1]));
    tbl.push_back(R(0,0,0,1, 1,0,0,1, 2, cn[2]));
    tbl.push_back(R(0,0,0,0, 0,0,0,1, 0, 0));
    run_table("mid_reset");
    kick(0);
    for (int j = 0; j < 20; j++) begin
      u = 4'(j);
      tbl.push_back(R(0,0,0,0, 1,0,0,1, u, cn[u]));
    end
    tbl.push_back(R(0,0,0,0, 0,1,1,0, 0, 0));
    run_table("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
